b_dis_mux: RTL and testbench
============================

// Module: b_dis_mux
// PURPOSE
// - Parametrised successor to the calculator 7-segment decoder.
// - Captures a signed-magnitude result on a load strobe and converts it to decimal with a sequential shift-add-3 (double-dabble) unit.
// - Drives a time-multiplexed N-digit common-anode display with leading-zero blanking, a floating minus sign, an "Err" message and an anti-ghost blank slot.
// - Sits between the ALU/keypad datapath and the board display pins.
// PARAMETERS
// DATA_W       8   magnitude width; NBCD = (DATA_W*3)/10+1 decimal digits (pkg function)
// DIGITS       4   number of physical digits, >=2
// REFRESH_DIV  1000  clocks per digit slot, >=2
// GHOST_CYC    2   clocks at start of each slot with all selects off, < REFRESH_DIV
// PORTS
// i_sys_clock              in   1        system clock
// i_sys_reset              in   1        asynchronous, active-low reset
// i_b_dis_load             in   1        capture strobe, accepted only when o_b_dis_busy=0
// i_b_dis_value            in   DATA_W   unsigned magnitude
// i_b_dis_neg              in   1        value is negative
// i_b_dis_ovf              in   1        upstream overflow, show "Err"
// o_b_dis_busy             out  1        conversion in progress
// o_b_dis_dis_code         out  7        {g,f,e,d,c,b,a}, active-low
// o_b_dis_sel              out  DIGITS   one-hot-low digit enable, bit0 = rightmost
// BEHAVIOUR
// - Reset: busy=0, frame=all blank, sel=all 1, dis_code=7'h7F, scan counters=0, FSM=IDLE.
// - Reset mid-conversion: same values; the conversion aborts and no partial frame is shown.
// - FSM states are IDLE, CONV, COMMIT.
// - IDLE + load: latch value/neg/ovf.
//   - If ovf=1, go to COMMIT directly.
//   - Otherwise, go to CONV with the BCD accumulator cleared.
//   - busy=1 from the next edge.
// - CONV: one shift-add-3 iteration per clock, DATA_W clocks, then go to COMMIT.
// - COMMIT: write the frame register, set busy=0 and return to IDLE, all on one edge.
//   - Latency is DATA_W+1 clocks after the load edge (1 clock if ovf).
// - Load while busy=1 is ignored, with no queuing.
// - The old frame stays displayed until COMMIT. The frame update is atomic.
// - Frame build, with m = index of the most significant nonzero BCD digit (m=0 if value=0):
//   - Digits m..0 show decimal. Digits above m are blank, so value 0 shows "0".
//   - If neg=1 and value!=0, digit m+1 shows '-' (segment g only). neg with value 0 shows "0".
//   - Digits above the number (and above the sign, if shown) are blank.
//   - If ovf=1, or m>DIGITS-1, or (neg and m+1>DIGITS-1), the frame is "Err" on digits 2..0 with the rest blank.
// - Segment codes (active-high {g..a}, output inverted):
//   - digits 0..9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F
//   - '-' = 40, 'E' = 79, 'r' = 50, blank = 00
// - Scan:
//   - A slot counter counts 0..REFRESH_DIV-1.
//   - On wrap, the digit index advances 0..DIGITS-1 and then wraps to 0.
//   - While slot counter < GHOST_CYC: sel = all 1, dis_code = 7'h7F.
//   - Otherwise: sel[idx] = 0 and dis_code = frame[idx].
//   - Outputs are registered, one clock behind the counters.
//   - The scan runs continuously and independently of load/busy.
// STRUCTURE
// - b_dis_pkg: NBCD function, segment constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_R, SEG_BLANK) and the FSM state enum.
// - Sub-module b_dis_bin2bcd (parametrised DATA_W): sequential double-dabble with start/done. This module holds the FSM, frame builder and scanner.
// TESTING (DATA_W=8, DIGITS=4, REFRESH_DIV=4, GHOST_CYC=1)
// 1. Reset held low for 5 clocks -> sel=4'b1111, dis_code=7'h7F, busy=0 throughout.
// 2. Load value=66, neg=0 -> busy high for exactly 9 clocks.
//    - Then, per slot: sel 1110 and 1101 show 7'h02 ('6'); sel 1011 and 0111 show 7'h7F.
// 3. Load value=66, neg=1 -> digit2 shows 7'h3F ('-').
//    - Load value=0, neg=1 -> only digit0 lit, showing 7'h40 ('0').
// 4. Load ovf=1 -> busy high for 1 clock; digits 2..0 show 7'h06 ('E'), 7'h2F ('r'), 7'h2F ('r'); digit3 shows 7'h7F.
// 5. Load 255, then load 17 on the following clock while busy -> the second load is ignored; the display shows "255" on digits 2..0 (7'h24, 7'h12, 7'h12); a later idle load of 17 displays "17".
// 6. Display "66", then load 200 and pull reset low 4 clocks in -> immediately blank, busy=0; after release, load 5 shows "5".

Source files
------------

// File: rtl/b_dis_pkg.sv
// Shared definitions for the multiplexed signed-decimal display driver:
// BCD digit count, segment patterns and controller states.
package b_dis_pkg;

  function automatic int nbcd(input int data_w);
    return (data_w * 3) / 10 + 1;
  endfunction

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_MINUS = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/b_dis_mux_if.sv
// Load/value handshake from the datapath and the display pin bundle.
interface b_dis_mux_if #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 4
);
  logic              i_b_dis_load;
  logic [DATA_W-1:0] i_b_dis_value;
  logic              i_b_dis_neg;
  logic              i_b_dis_ovf;
  logic              o_b_dis_busy;
  logic [6:0]        o_b_dis_dis_code;
  logic [DIGITS-1:0] o_b_dis_sel;

  modport slave (
    input  i_b_dis_load, i_b_dis_value, i_b_dis_neg, i_b_dis_ovf,
    output o_b_dis_busy, o_b_dis_dis_code, o_b_dis_sel
  );

  modport master (
    output i_b_dis_load, i_b_dis_value, i_b_dis_neg, i_b_dis_ovf,
    input  o_b_dis_busy, o_b_dis_dis_code, o_b_dis_sel
  );
endinterface

// File: rtl/b_dis_bin2bcd.sv
// Sequential double-dabble converter: one shift-add-3 step per clock after start.
// done is high during the cycle whose closing edge performs the final step.
module b_dis_bin2bcd
  import b_dis_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NBCD   = nbcd(DATA_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin,
  output logic [4*NBCD-1:0]   bcd,
  output logic                done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_r;
  logic [4*NBCD-1:0] bcd_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              last_r;
  logic [4*NBCD-1:0] adj_s;
  logic [4*NBCD-1:0] bcd_nxt_s;
  logic [DATA_W-1:0] bin_nxt_s;

  // One double-dabble step: correct digits >= 5, then shift left through the accumulator
  always_comb begin
    adj_s = bcd_r;
    for (int i = 0; i < NBCD; i++) begin
      if (adj_s[4*i +: 4] >= 4'd5) begin
        adj_s[4*i +: 4] = adj_s[4*i +: 4] + 4'd3;
      end else begin
        adj_s[4*i +: 4] = adj_s[4*i +: 4];
      end
    end
    bcd_nxt_s = {adj_s[4*NBCD-2:0], bin_r[DATA_W-1]};
    bin_nxt_s = {bin_r[DATA_W-2:0], 1'b0};
  end

  // Iteration counter and shift registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_r  <= '0;
      bcd_r  <= '0;
      cnt_r  <= '0;
      last_r <= 1'b0;
    end else if (start) begin
      bin_r  <= bin;
      bcd_r  <= '0;
      cnt_r  <= CNT_W'(DATA_W);
      last_r <= (DATA_W == 1);
    end else if (cnt_r != '0) begin
      bin_r  <= bin_nxt_s;
      bcd_r  <= bcd_nxt_s;
      cnt_r  <= cnt_r - CNT_W'(1);
      last_r <= (cnt_r == CNT_W'(2));
    end else begin
      last_r <= 1'b0;
    end
  end

  assign bcd  = bcd_r;
  assign done = last_r;

endmodule

// File: rtl/b_dis_mux.sv
// Signed-magnitude to multiplexed 7-segment display driver with blanking,
// floating minus sign, "Err" message and an anti-ghost gap at each digit slot.
module b_dis_mux
  import b_dis_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int GHOST_CYC   = 2
) (
  input  logic        i_sys_clock,
  input  logic        i_sys_reset,
  b_dis_mux_if.slave  bus
);

  localparam int NBCD   = nbcd(DATA_W);
  localparam int PAD_N  = (NBCD > DIGITS) ? NBCD : DIGITS;
  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(DIGITS);

  state_t                  state_r;
  logic [DATA_W-1:0]       value_r;
  logic                    neg_r;
  logic                    ovf_r;
  logic                    busy_r;
  logic [DIGITS-1:0][6:0]  frame_r;
  logic [DIGITS-1:0][6:0]  frame_s;
  logic                    start_s;
  logic                    conv_done_s;
  logic [4*NBCD-1:0]       bcd_s;
  logic [4*PAD_N-1:0]      dig_s;
  int                      msd_s;
  logic                    sign_s;
  logic                    err_s;
  logic [SLOT_W-1:0]       slot_r;
  logic [IDX_W-1:0]        idx_r;
  logic [DIGITS-1:0]       sel_r;
  logic [6:0]              code_r;

  assign start_s = (state_r == ST_IDLE) && bus.i_b_dis_load && !bus.i_b_dis_ovf;

  b_dis_bin2bcd #(.DATA_W(DATA_W), .NBCD(NBCD)) u_bin2bcd (
    .clk   (i_sys_clock),
    .rst_n (i_sys_reset),
    .start (start_s),
    .bin   (bus.i_b_dis_value),
    .bcd   (bcd_s),
    .done  (conv_done_s)
  );

  assign dig_s = (4*PAD_N)'(bcd_s);

  // Frame builder: blank above the most significant digit, sign just above it
  always_comb begin
    msd_s = 0;
    for (int i = 0; i < PAD_N; i++) begin
      msd_s = (dig_s[4*i +: 4] != 4'd0) ? i : msd_s;
    end
    sign_s = neg_r && (value_r != '0);
    err_s  = ovf_r || (msd_s > DIGITS - 1) || (sign_s && (msd_s + 1 > DIGITS - 1));
    for (int j = 0; j < DIGITS; j++) begin
      if (err_s) begin
        if (j == 2) begin
          frame_s[j] = SEG_E;
        end else if (j < 2) begin
          frame_s[j] = SEG_R;
        end else begin
          frame_s[j] = SEG_BLANK;
        end
      end else if (j <= msd_s) begin
        frame_s[j] = seg_digit(dig_s[4*j +: 4]);
      end else if (sign_s && (j == msd_s + 1)) begin
        frame_s[j] = SEG_MINUS;
      end else begin
        frame_s[j] = SEG_BLANK;
      end
    end
  end

  // Load/convert/commit controller; the frame only changes on the commit edge
  always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
    if (!i_sys_reset) begin
      state_r <= ST_IDLE;
      value_r <= '0;
      neg_r   <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      frame_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_b_dis_load) begin
            value_r <= bus.i_b_dis_value;
            neg_r   <= bus.i_b_dis_neg;
            ovf_r   <= bus.i_b_dis_ovf;
            busy_r  <= 1'b1;
            state_r <= bus.i_b_dis_ovf ? ST_COMMIT : ST_CONV;
          end
        end
        ST_CONV: begin
          if (conv_done_s) begin
            state_r <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          frame_r <= frame_s;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Free-running scan with all selects off at the start of each slot
  always_ff @(posedge i_sys_clock or negedge i_sys_reset) begin
    if (!i_sys_reset) begin
      slot_r <= '0;
      idx_r  <= '0;
      sel_r  <= '1;
      code_r <= 7'h7F;
    end else begin
      if (slot_r == SLOT_W'(REFRESH_DIV - 1)) begin
        slot_r <= '0;
        idx_r  <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
      end else begin
        slot_r <= slot_r + SLOT_W'(1);
      end
      if (slot_r < SLOT_W'(GHOST_CYC)) begin
        sel_r  <= '1;
        code_r <= 7'h7F;
      end else begin
        sel_r  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_r);
        code_r <= ~frame_r[idx_r];
      end
    end
  end

  assign bus.o_b_dis_busy     = busy_r;
  assign bus.o_b_dis_dis_code = code_r;
  assign bus.o_b_dis_sel      = sel_r;

endmodule

// File: tb/tb_b_dis_mux.sv
// Directed bench for b_dis_mux: load vectors from a table, then multi-cycle
// sequences for ignored loads and reset during conversion.
module tb_b_dis_mux;

  localparam int DATA_W = 8;
  localparam int DIGITS = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  b_dis_mux_if #(.DATA_W(DATA_W), .DIGITS(DIGITS)) bus ();

  b_dis_mux #(
    .DATA_W(DATA_W), .DIGITS(DIGITS), .REFRESH_DIV(4), .GHOST_CYC(1)
  ) dut (
    .i_sys_clock (clk),
    .i_sys_reset (rst_n),
    .bus         (bus)
  );

  typedef struct {
    string            name;
    logic [7:0]       value;
    logic             neg;
    logic             ovf;
    int               busy_cyc;
    logic [3:0][6:0]  exp;     // active-low code per digit, [0] = rightmost
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present a load for one clock; returns at the first sample point after the load edge
  task automatic do_load(input logic [7:0] v, input logic n, input logic o);
    @(negedge clk);
    bus.i_b_dis_load  = 1'b1;
    bus.i_b_dis_value = v;
    bus.i_b_dis_neg   = n;
    bus.i_b_dis_ovf   = o;
    @(negedge clk);
    bus.i_b_dis_load  = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (bus.o_b_dis_busy === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Watch one full scan (16 clocks) and compare every sample against the frame
  task automatic check_frame(input string name, input logic [3:0][6:0] exp);
    int         ghosts = 0;
    logic [3:0] seen   = 4'b0000;
    logic [3:0] sel;
    logic [3:0] pat;
    logic       legal;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sel   = bus.o_b_dis_sel;
      legal = (sel == 4'hF);
      if (sel == 4'hF) begin
        ghosts++;
        chk({name, "_ghost_code"}, 32'(bus.o_b_dis_dis_code), 32'h7F);
      end
      for (int d = 0; d < 4; d++) begin
        pat = ~(4'b0001 << d);
        if (sel == pat) begin
          legal   = 1'b1;
          seen[d] = 1'b1;
          chk($sformatf("%s_d%0d", name, d), 32'(bus.o_b_dis_dis_code), 32'(exp[d]));
        end
      end
      chk({name, "_sel_onehot"}, 32'(legal), 32'd1);
    end
    chk({name, "_ghost_slots"}, 32'(ghosts), 32'd4);
    chk({name, "_digits_seen"}, 32'(seen), 32'hF);
  endtask

  initial begin
    int n;
    vecs[0] = '{"v66",     8'd66,  1'b0, 1'b0, 9, {7'h7F, 7'h7F, 7'h02, 7'h02}};
    vecs[1] = '{"v66neg",  8'd66,  1'b1, 1'b0, 9, {7'h7F, 7'h3F, 7'h02, 7'h02}};
    vecs[2] = '{"v0neg",   8'd0,   1'b1, 1'b0, 9, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[3] = '{"ovf",     8'd42,  1'b0, 1'b1, 1, {7'h7F, 7'h06, 7'h2F, 7'h2F}};
    vecs[4] = '{"v255",    8'd255, 1'b0, 1'b0, 9, {7'h7F, 7'h24, 7'h12, 7'h12}};
    vecs[5] = '{"v255neg", 8'd255, 1'b1, 1'b0, 9, {7'h3F, 7'h24, 7'h12, 7'h12}};
    vecs[6] = '{"v100",    8'd100, 1'b0, 1'b0, 9, {7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[7] = '{"v9neg",   8'd9,   1'b1, 1'b0, 9, {7'h7F, 7'h7F, 7'h3F, 7'h10}};
    vecs[8] = '{"v128",    8'd128, 1'b0, 1'b0, 9, {7'h7F, 7'h79, 7'h24, 7'h00}};
    vecs[9] = '{"v0",      8'd0,   1'b0, 1'b0, 9, {7'h7F, 7'h7F, 7'h7F, 7'h40}};

    bus.i_b_dis_load  = 1'b0;
    bus.i_b_dis_value = 8'd0;
    bus.i_b_dis_neg   = 1'b0;
    bus.i_b_dis_ovf   = 1'b0;

    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_sel",  32'(bus.o_b_dis_sel),      32'hF);
      chk("rst_code", 32'(bus.o_b_dis_dis_code), 32'h7F);
      chk("rst_busy", 32'(bus.o_b_dis_busy),     32'd0);
    end
    rst_n = 1'b1;
    check_frame("post_rst", {7'h7F, 7'h7F, 7'h7F, 7'h7F});

    for (int i = 0; i < 10; i++) begin
      do_load(vecs[i].value, vecs[i].neg, vecs[i].ovf);
      measure_busy(n);
      chk({vecs[i].name, "_busy_cyc"}, 32'(n), 32'(vecs[i].busy_cyc));
      check_frame(vecs[i].name, vecs[i].exp);
    end

    // Second load while busy must be dropped
    @(negedge clk);
    bus.i_b_dis_load  = 1'b1;
    bus.i_b_dis_value = 8'd255;
    bus.i_b_dis_neg   = 1'b0;
    bus.i_b_dis_ovf   = 1'b0;
    @(negedge clk);
    chk("ign_busy_now", 32'(bus.o_b_dis_busy), 32'd1);
    bus.i_b_dis_value = 8'd17;
    @(negedge clk);
    bus.i_b_dis_load  = 1'b0;
    measure_busy(n);
    chk("ign_busy_rest", 32'(n), 32'd8);
    check_frame("ign_255", {7'h7F, 7'h24, 7'h12, 7'h12});
    do_load(8'd17, 1'b0, 1'b0);
    measure_busy(n);
    chk("v17_busy_cyc", 32'(n), 32'd9);
    check_frame("v17", {7'h7F, 7'h7F, 7'h79, 7'h78});

    // Reset during conversion blanks everything and discards the partial result
    do_load(8'd66, 1'b0, 1'b0);
    measure_busy(n);
    check_frame("pre_abort_66", {7'h7F, 7'h7F, 7'h02, 7'h02});
    do_load(8'd200, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("abort_busy_before", 32'(bus.o_b_dis_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.o_b_dis_busy),     32'd0);
    chk("abort_sel",  32'(bus.o_b_dis_sel),      32'hF);
    chk("abort_code", 32'(bus.o_b_dis_dis_code), 32'h7F);
    repeat (2) begin
      @(negedge clk);
      chk("abort_hold_sel", 32'(bus.o_b_dis_sel), 32'hF);
    end
    rst_n = 1'b1;
    check_frame("post_abort", {7'h7F, 7'h7F, 7'h7F, 7'h7F});
    do_load(8'd5, 1'b0, 1'b0);
    measure_busy(n);
    chk("v5_busy_cyc", 32'(n), 32'd9);
    check_frame("v5", {7'h7F, 7'h7F, 7'h7F, 7'h12});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
